// File: rtl/router_fifo_if.sv
// router_fifo_if: write/read handshake and status bundle between the synchroniser, router_fifo and the destination client
interface router_fifo_if #(parameter int WIDTH = 8);
  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  modport master (output soft_reset, write_enb, read_enb, lfd_state, data_in, input data_out, full, empty);
  modport slave  (input soft_reset, write_enb, read_enb, lfd_state, data_in, output data_out, full, empty);
endinterface

// File: rtl/router_fifo.sv
// router_fifo: per-port packet buffer with header tagging and readout byte counter; ROUTER_FIFO_TRISTATE_EN makes idle data_out high-Z
module router_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input logic          clock,
  input logic          reset,
  router_fifo_if.slave bus
);
  logic [WIDTH:0]   r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic [6:0]       r_count;
  logic [WIDTH-1:0] r_data;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;
  logic             w_idle;
  logic [WIDTH:0]   w_entry;
  assign w_empty = r_wr_ptr == r_rd_ptr;
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) && (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_wr    = bus.write_enb && !w_full && !bus.soft_reset;
  assign w_rd    = bus.read_enb && !w_empty && !bus.soft_reset;
  assign w_idle  = bus.soft_reset || (r_count == 7'd0 && w_empty);
  assign w_entry = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign bus.full  = w_full;
  assign bus.empty = w_empty;
  // Storage: each entry keeps the byte plus its header tag; hard reset clears tags too
  always_ff @(posedge clock or posedge reset)
    if (reset)
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    else if (w_wr)
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
  // Pointers carry a wrap bit so full and empty are distinguishable
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (bus.soft_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  // Remaining-bytes counter: header loads length plus parity, others count down and saturate at zero
  always_ff @(posedge clock or posedge reset)
    if (reset)
      r_count <= '0;
    else if (bus.soft_reset)
      r_count <= '0;
    else if (w_rd)
      r_count <= w_entry[WIDTH] ? 7'(w_entry[WIDTH-1:2]) + 7'd1 : (r_count != 7'd0 ? r_count - 7'd1 : 7'd0);
  // Registered read data, forced to idle between packets and on flush
  always_ff @(posedge clock or posedge reset)
    if (reset)
      r_data <= '0;
    else if (w_idle)
      r_data <= '0;
    else if (w_rd)
      r_data <= w_entry[WIDTH-1:0];
`ifdef ROUTER_FIFO_TRISTATE_EN
  logic r_idle;
  // Tracks whether data_out should release the shared bus
  always_ff @(posedge clock or posedge reset)
    if (reset)
      r_idle <= 1'b1;
    else if (w_idle)
      r_idle <= 1'b1;
    else if (w_rd)
      r_idle <= 1'b0;
  assign bus.data_out = r_idle ? {WIDTH{1'bz}} : r_data;
`else
  assign bus.data_out = r_data;
`endif
endmodule

// File: doc/router_fifo.md
# router_fifo

Output-port buffer of the 1x3 packet router, directly downstream of the synchroniser. One instance per destination port. It stores bytes routed to it by the synchroniser's one-hot `write_enb` bit and tags each packet's header byte. It tracks the remaining bytes of the packet being read out, and honours the synchroniser's per-port `soft_reset` time-out.

## Interface
- `DEPTH`, 16, number of storage entries; must be a power of two.
- `ADDR_W`, 4, log2(DEPTH).
- `WIDTH`, 8, data byte width. Each storage entry is WIDTH+1 bits: bit WIDTH is the header tag.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `soft_reset`  in  1  synchronous, active-high flush, driven by the synchroniser's `soft_reset_N`.
- `write_enb`  in  1  write request, driven by the synchroniser's `write_enb[N]`.
- `read_enb`  in  1  read request from the destination client.
- `lfd_state`  in  1  marks the byte on `data_in` as a packet header (load-first-data).
- `data_in`  in  WIDTH  byte to store. For a header byte, [7:2] is the payload length and [1:0] is the address.
- `data_out`  out  WIDTH  registered read data.
- `full`  out  1  all DEPTH entries occupied; feeds the synchroniser's `full_N`.
- `empty`  out  1  no entries occupied; feeds the synchroniser's `empty_N`, whose inverse is `vld_out_N`.

## Operation
- Write and read pointers are ADDR_W+1 bits wide; the extra MSB is the wrap bit.
- `empty` = (wr_ptr == rd_ptr).
- `full` = MSBs differ and the low ADDR_W bits are equal.
- Both flags are combinational from the pointer registers.
- **Write:** when `write_enb` && !`full`, store {`lfd_state`, `data_in`} at wr_ptr[ADDR_W-1:0] and increment wr_ptr (mod 2^(ADDR_W+1)). A write while full is dropped silently; no pointer or memory change.
- **Read:** when `read_enb` && !`empty`, data_out <= entry[WIDTH-1:0] at rd_ptr, and rd_ptr increments.
- **Packet counter** (7 bits, reset 0):
  - Reading a tagged entry loads data[7:2] + 1, i.e. payload plus parity byte.
  - Reading an untagged entry with counter != 0 decrements it.
  - Reading an untagged entry with counter == 0 leaves it at 0; it never wraps.
- **Idle output:** when (counter == 0 && `empty`) or `soft_reset`, data_out is driven idle (see Configuration). Otherwise, with no read, data_out holds its last value.
- **Simultaneous read and write:**
  - Both are honoured when neither is blocked.
  - At full, the read proceeds and the write is dropped, because `full` is evaluated before the edge.
  - At empty, the write proceeds and the read is ignored.
- **Priority per edge:** `reset` (async) > `soft_reset` > read/write.
- **`soft_reset`** clears both pointers and the counter and idles data_out. Memory contents are don't-care. A write or read in the same cycle is discarded.
- **`reset`** asynchronously clears the pointers, the counter, every memory entry (including tag bits) and data_out. Release is synchronous to `clock` at the system level.

## Timing
- Reset values: data_out = idle value, `full` = 0, `empty` = 1, counter = 0.
- Write-to-`empty`-deassert: 1 cycle (flag low the cycle after the write edge).
- Read latency: data_out is valid 1 cycle after the edge at which `read_enb` && !`empty` was sampled.
- `full` asserts in the cycle after the DEPTH-th un-read write and deasserts in the cycle after the first read.
- `soft_reset` takes effect at the same edge it is sampled. `empty` = 1 in the following cycle.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- `ROUTER_FIFO_TRISTATE_EN` defined: the idle value of data_out is {WIDTH{1'bz}}, so port outputs can share a bus.
- `ROUTER_FIFO_TRISTATE_EN` undefined (default): the idle value of data_out is {WIDTH{1'b0}}; there are no tri-state drivers in the block.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** assert `reset` mid-cycle with 5 entries stored → immediately `empty`=1, `full`=0, data_out=idle; 3 reads after release return no data and `empty` stays 1.
- **Packet readout:**
  - Write header 8'h0D with `lfd_state`=1 (length 3), then 8'hA1, 8'hA2, 8'hA3 and parity 8'h5C.
  - Read 5 bytes back-to-back → data_out sequence 0D, A1, A2, A3, 5C, one cycle after each read.
  - Counter sequence 4, 3, 2, 1, 0.
  - data_out goes idle the cycle after the last read.
- **Fill:** 16 writes → `full`=1 after the 16th; a 17th write (8'hFF) is dropped; 16 reads return the original bytes in order and `empty`=1 after.
- **Simultaneous at full:** with `full`=1, assert `read_enb` and `write_enb` together → oldest byte read, new byte dropped, `full`=0 next cycle, 15 entries remain.
- **Soft reset mid-packet:**
  - Write a header plus 2 payload bytes and read the header.
  - Pulse `soft_reset` together with `write_enb` → `empty`=1 next cycle, counter=0, data_out idle, concurrent write discarded.
- **Both builds:** run the packet-readout scenario with and without `ROUTER_FIFO_TRISTATE_EN` → idle data_out is 8'hzz and 8'h00 respectively.
